// File: rtl/cache_bus_rd_mux.sv
// cache_bus_rd_mux: N-to-1 multiplexer for the read half (AR/R) of the CacheBus.
// AR requests from MASTER_NUM cache-side masters are arbitrated round-robin
// into one registered output slot, with the master index prepended to the ID.
// R beats are routed back combinationally using the upper ID bits. Each
// master's in-flight bursts are counted and it is throttled at MAX_OUTSTANDING.
//
// Handshake semantics (all channels): a transfer occurs on the rising clk edge
// where valid and ready are both high. A source asserting valid holds valid and
// its payload stable until that edge; valid never waits on ready.
module cache_bus_rd_mux #(
    parameter int MASTER_NUM      = 4,
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 64,
    parameter int ID_WIDTH        = 4,
    parameter int USER_WIDTH      = 1,
    parameter int MAX_OUTSTANDING = 8,
    localparam int IDX_W          = $clog2(MASTER_NUM),
    localparam int SID_W          = ID_WIDTH + IDX_W
) (
    input  logic                             clk,
    input  logic                             rst,
    // upstream AR
    input  logic [MASTER_NUM-1:0]            m_ar_valid,
    output logic [MASTER_NUM-1:0]            m_ar_ready,
    input  logic [MASTER_NUM*ID_WIDTH-1:0]   m_ar_id,
    input  logic [MASTER_NUM*ADDR_WIDTH-1:0] m_ar_addr,
    input  logic [MASTER_NUM*8-1:0]          m_ar_len,
    input  logic [MASTER_NUM*3-1:0]          m_ar_size,
    input  logic [MASTER_NUM*2-1:0]          m_ar_burst,
    input  logic [MASTER_NUM*4-1:0]          m_ar_snoop,
    input  logic [MASTER_NUM*USER_WIDTH-1:0] m_ar_user,
    // upstream R
    output logic [MASTER_NUM-1:0]            m_r_valid,
    input  logic [MASTER_NUM-1:0]            m_r_ready,
    output logic [ID_WIDTH-1:0]              m_r_id,
    output logic [DATA_WIDTH-1:0]            m_r_data,
    output logic [4:0]                       m_r_resp,
    output logic                             m_r_last,
    output logic [USER_WIDTH-1:0]            m_r_user,
    // downstream AR
    output logic                             s_ar_valid,
    input  logic                             s_ar_ready,
    output logic [SID_W-1:0]                 s_ar_id,
    output logic [ADDR_WIDTH-1:0]            s_ar_addr,
    output logic [7:0]                       s_ar_len,
    output logic [2:0]                       s_ar_size,
    output logic [1:0]                       s_ar_burst,
    output logic [3:0]                       s_ar_snoop,
    output logic [USER_WIDTH-1:0]            s_ar_user,
    // downstream R
    input  logic                             s_r_valid,
    output logic                             s_r_ready,
    input  logic [SID_W-1:0]                 s_r_id,
    input  logic [DATA_WIDTH-1:0]            s_r_data,
    input  logic [4:0]                       s_r_resp,
    input  logic                             s_r_last,
    input  logic [USER_WIDTH-1:0]            s_r_user
);

    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_OUTSTANDING);
    localparam logic [IDX_W:0]   NUM_EXT  = (IDX_W + 1)'(MASTER_NUM);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(MASTER_NUM - 1);

    // per-master views of the packed AR buses
    logic [ID_WIDTH-1:0]   ar_id_a    [MASTER_NUM];
    logic [ADDR_WIDTH-1:0] ar_addr_a  [MASTER_NUM];
    logic [7:0]            ar_len_a   [MASTER_NUM];
    logic [2:0]            ar_size_a  [MASTER_NUM];
    logic [1:0]            ar_burst_a [MASTER_NUM];
    logic [3:0]            ar_snoop_a [MASTER_NUM];
    logic [USER_WIDTH-1:0] ar_user_a  [MASTER_NUM];

    // outstanding burst counters and their update strobes
    logic [CNT_W-1:0]      cnt [MASTER_NUM];
    logic [MASTER_NUM-1:0] inc;
    logic [MASTER_NUM-1:0] dec;
    logic [MASTER_NUM-1:0] eligible;

    // arbitration state
    logic [IDX_W-1:0] ptr;
    logic [IDX_W-1:0] grant_idx;
    logic [IDX_W:0]   cand_sum;
    logic             grant_valid;
    logic             slot_accept;

    // R routing
    logic [IDX_W-1:0] r_idx;
    logic             r_idx_ok;
    logic             r_last_hs;

    for (genvar i = 0; i < MASTER_NUM; i++) begin : g_unpack
        assign ar_id_a[i]    = m_ar_id[i*ID_WIDTH +: ID_WIDTH];
        assign ar_addr_a[i]  = m_ar_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        assign ar_len_a[i]   = m_ar_len[i*8 +: 8];
        assign ar_size_a[i]  = m_ar_size[i*3 +: 3];
        assign ar_burst_a[i] = m_ar_burst[i*2 +: 2];
        assign ar_snoop_a[i] = m_ar_snoop[i*4 +: 4];
        assign ar_user_a[i]  = m_ar_user[i*USER_WIDTH +: USER_WIDTH];
        // a master may only compete while it has room for another burst
        assign eligible[i]   = m_ar_valid[i] && (cnt[i] < CNT_MAX);
    end

    // The slot refills in the same cycle it drains, giving one AR per cycle.
    assign slot_accept = !s_ar_valid || s_ar_ready;

    // Round-robin search: first eligible master at or after ptr, wrapping.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        cand_sum    = '0;
        if (slot_accept && !rst) begin
            for (int k = 0; k < MASTER_NUM; k++) begin
                cand_sum = {1'b0, ptr} + (IDX_W + 1)'(k);
                if (cand_sum >= NUM_EXT) begin
                    cand_sum = cand_sum - NUM_EXT;
                end
                if (!grant_valid && eligible[cand_sum[IDX_W-1:0]]) begin
                    grant_valid = 1'b1;
                    grant_idx   = cand_sum[IDX_W-1:0];
                end
            end
        end
    end

    // Ready goes only to the granted master; grant implies valid, so grant is the handshake.
    always_comb begin
        m_ar_ready = '0;
        if (grant_valid) begin
            m_ar_ready[grant_idx] = 1'b1;
        end
    end

    // AR output slot: load on handshake, clear when drained, hold while stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            s_ar_valid <= 1'b0;
            s_ar_id    <= '0;
            s_ar_addr  <= '0;
            s_ar_len   <= '0;
            s_ar_size  <= '0;
            s_ar_burst <= '0;
            s_ar_snoop <= '0;
            s_ar_user  <= '0;
        end else if (grant_valid) begin
            s_ar_valid <= 1'b1;
            s_ar_id    <= {grant_idx, ar_id_a[grant_idx]};
            s_ar_addr  <= ar_addr_a[grant_idx];
            s_ar_len   <= ar_len_a[grant_idx];
            s_ar_size  <= ar_size_a[grant_idx];
            s_ar_burst <= ar_burst_a[grant_idx];
            s_ar_snoop <= ar_snoop_a[grant_idx];
            s_ar_user  <= ar_user_a[grant_idx];
        end else if (s_ar_ready) begin
            s_ar_valid <= 1'b0;
        end
    end

    // Pointer moves past the winner; it holds when nothing is granted.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else if (grant_valid) begin
            ptr <= (grant_idx == LAST_IDX) ? '0 : grant_idx + IDX_W'(1);
        end
    end

    assign r_idx = s_r_id[SID_W-1 -: IDX_W];

    // With a non-power-of-two master count some index codes name no master.
    if ((1 << IDX_W) == MASTER_NUM) begin : g_idx_pow2
        assign r_idx_ok = 1'b1;
    end else begin : g_idx_range
        assign r_idx_ok = ({1'b0, r_idx} < NUM_EXT);
    end

    // Route the R beat to its master; beats with an unknown index are drained.
    always_comb begin
        m_r_valid = '0;
        s_r_ready = 1'b1;
        if (r_idx_ok) begin
            m_r_valid[r_idx] = s_r_valid;
            s_r_ready        = m_r_ready[r_idx];
        end
    end

    assign m_r_id   = s_r_id[ID_WIDTH-1:0];
    assign m_r_data = s_r_data;
    assign m_r_resp = s_r_resp;
    assign m_r_last = s_r_last;
    assign m_r_user = s_r_user;

    assign r_last_hs = s_r_valid && s_r_ready && s_r_last && r_idx_ok;

    // Report beats carrying an index that maps to no master.
    always @(posedge clk) begin
        if (!rst && s_r_valid) begin
            assert (r_idx_ok) else $error("cache_bus_rd_mux: R beat with out-of-range master index %0d", r_idx);
        end
    end

    for (genvar i = 0; i < MASTER_NUM; i++) begin : g_cnt
        assign inc[i] = grant_valid && (grant_idx == IDX_W'(i));
        assign dec[i] = r_last_hs && (r_idx == IDX_W'(i));

        // Count bursts from AR acceptance (slot included) until their last R beat.
        always_ff @(posedge clk) begin
            if (rst) begin
                cnt[i] <= '0;
            end else if (inc[i] && !dec[i]) begin
                cnt[i] <= cnt[i] + CNT_W'(1);
            end else if (dec[i] && !inc[i]) begin
                if (cnt[i] != '0) begin
                    cnt[i] <= cnt[i] - CNT_W'(1);
                end
            end
        end

        // A last beat for a master with nothing outstanding is a slave protocol error.
        always @(posedge clk) begin
            if (!rst && dec[i] && !inc[i]) begin
                assert (cnt[i] != '0) else $error("cache_bus_rd_mux: R last for master %0d with no outstanding burst", i);
            end
        end
    end

endmodule

// File: tb/tb_cache_bus_rd_mux.sv
// Testbench for cache_bus_rd_mux: random masters and a random downstream
// slave, with a reference model of round-robin arbitration, outstanding limits
// and R routing. Expected AR/R transfers are queued and checked by monitors.
module tb_cache_bus_rd_mux;
  localparam int NM   = 4;
  localparam int AW   = 32;
  localparam int DW   = 64;
  localparam int IW   = 4;
  localparam int UW   = 1;
  localparam int MAXO = 2;
  localparam int SW   = IW + 2;

  logic clk = 1'b0;
  logic rst;
  logic [NM-1:0]    m_ar_valid, m_ar_ready;
  logic [NM*IW-1:0] m_ar_id;
  logic [NM*AW-1:0] m_ar_addr;
  logic [NM*8-1:0]  m_ar_len;
  logic [NM*3-1:0]  m_ar_size;
  logic [NM*2-1:0]  m_ar_burst;
  logic [NM*4-1:0]  m_ar_snoop;
  logic [NM*UW-1:0] m_ar_user;
  logic [NM-1:0]    m_r_valid, m_r_ready;
  logic [IW-1:0]    m_r_id;
  logic [DW-1:0]    m_r_data;
  logic [4:0]       m_r_resp;
  logic             m_r_last;
  logic [UW-1:0]    m_r_user;
  logic             s_ar_valid, s_ar_ready;
  logic [SW-1:0]    s_ar_id;
  logic [AW-1:0]    s_ar_addr;
  logic [7:0]       s_ar_len;
  logic [2:0]       s_ar_size;
  logic [1:0]       s_ar_burst;
  logic [3:0]       s_ar_snoop;
  logic [UW-1:0]    s_ar_user;
  logic             s_r_valid, s_r_ready;
  logic [SW-1:0]    s_r_id;
  logic [DW-1:0]    s_r_data;
  logic [4:0]       s_r_resp;
  logic             s_r_last;
  logic [UW-1:0]    s_r_user;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  cache_bus_rd_mux #(
    .MASTER_NUM(NM), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW),
    .USER_WIDTH(UW), .MAX_OUTSTANDING(MAXO)
  ) dut (
    .clk(clk), .rst(rst),
    .m_ar_valid(m_ar_valid), .m_ar_ready(m_ar_ready), .m_ar_id(m_ar_id),
    .m_ar_addr(m_ar_addr), .m_ar_len(m_ar_len), .m_ar_size(m_ar_size),
    .m_ar_burst(m_ar_burst), .m_ar_snoop(m_ar_snoop), .m_ar_user(m_ar_user),
    .m_r_valid(m_r_valid), .m_r_ready(m_r_ready), .m_r_id(m_r_id),
    .m_r_data(m_r_data), .m_r_resp(m_r_resp), .m_r_last(m_r_last), .m_r_user(m_r_user),
    .s_ar_valid(s_ar_valid), .s_ar_ready(s_ar_ready), .s_ar_id(s_ar_id),
    .s_ar_addr(s_ar_addr), .s_ar_len(s_ar_len), .s_ar_size(s_ar_size),
    .s_ar_burst(s_ar_burst), .s_ar_snoop(s_ar_snoop), .s_ar_user(s_ar_user),
    .s_r_valid(s_r_valid), .s_r_ready(s_r_ready), .s_r_id(s_r_id),
    .s_r_data(s_r_data), .s_r_resp(s_r_resp), .s_r_last(s_r_last), .s_r_user(s_r_user)
  );

  // ---------------- scoreboard state ----------------
  typedef struct packed {
    logic [SW-1:0] id;
    logic [AW-1:0] addr;
    logic [7:0]    len;
    logic [2:0]    size;
    logic [1:0]    burst;
    logic [3:0]    snoop;
    logic [UW-1:0] user;
  } ar_t;

  typedef struct packed {
    logic [NM-1:0] vld;
    logic          rdy;
    logic [IW-1:0] id;
    logic [DW-1:0] data;
    logic [4:0]    resp;
    logic          last;
    logic [UW-1:0] user;
  } r_t;

  typedef struct {
    logic [SW-1:0] sid;
    int            len;
    int            sent;
  } burst_t;

  ar_t    exp_ar_q[$];
  r_t     exp_r_q[$];
  burst_t slv_q[$];

  int total = 0;
  int bad   = 0;

  // master-side request registers (held until accepted)
  logic          pend [NM];
  logic [IW-1:0] mid  [NM];
  logic [AW-1:0] maddr[NM];
  logic [7:0]    mlen [NM];
  logic [2:0]    msize[NM];
  logic [1:0]    mbst [NM];
  logic [3:0]    msnp [NM];
  logic [UW-1:0] musr [NM];

  // reference model: fairness pointer, in-flight bursts, slot occupancy
  logic [1:0] ptr_m;
  int         cnt_m[NM];
  logic       slot_m;
  logic       g_ok;
  logic [1:0] g;
  logic       r_hs;
  logic       r_busy;
  int         cur_k;

  // stimulus knobs (percentages)
  int req_pct, ardy_pct, rrdy_pct, rv_pct;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    ptr_m  = 2'd0;
    slot_m = 1'b0;
    r_busy = 1'b0;
    for (int i = 0; i < NM; i++) cnt_m[i] = 0;
    exp_ar_q.delete();
    slv_q.delete();
  endtask

  // ---------------- driver ----------------
  task automatic drive_inputs(input int cyc);
    logic [1:0] ridx;
    r_t e;
    rst = (cyc == 1200);
    for (int i = 0; i < NM; i++) begin
      if (!pend[i] && $urandom_range(0, 99) < req_pct) begin
        pend[i]  = 1'b1;
        mid[i]   = IW'($urandom);
        maddr[i] = $urandom;
        mlen[i]  = 8'($urandom_range(0, 3));
        msize[i] = 3'($urandom);
        mbst[i]  = 2'($urandom);
        msnp[i]  = 4'($urandom);
        musr[i]  = UW'($urandom);
      end
      m_ar_valid[i]            = pend[i];
      m_ar_id[i*IW +: IW]      = mid[i];
      m_ar_addr[i*AW +: AW]    = maddr[i];
      m_ar_len[i*8 +: 8]       = mlen[i];
      m_ar_size[i*3 +: 3]      = msize[i];
      m_ar_burst[i*2 +: 2]     = mbst[i];
      m_ar_snoop[i*4 +: 4]     = msnp[i];
      m_ar_user[i*UW +: UW]    = musr[i];
      m_r_ready[i]             = ($urandom_range(0, 99) < rrdy_pct);
    end
    s_ar_ready = rst ? 1'b0 : ($urandom_range(0, 99) < ardy_pct);

    if (rst) begin
      s_r_valid = 1'b0;
    end else if (!r_busy) begin
      if (slv_q.size() > 0 && $urandom_range(0, 99) < rv_pct) begin
        cur_k = 0;
        if (slv_q.size() > 1 && slv_q[1].sid != slv_q[0].sid && $urandom_range(0, 1) == 1) cur_k = 1;
        s_r_valid = 1'b1;
        s_r_id    = slv_q[cur_k].sid;
        s_r_data  = {$urandom, $urandom};
        s_r_resp  = 5'($urandom);
        s_r_last  = (slv_q[cur_k].sent == slv_q[cur_k].len);
        s_r_user  = UW'($urandom);
      end else begin
        s_r_valid = 1'b0;
        s_r_id    = SW'($urandom);
      end
    end

    if (s_r_valid) begin
      ridx   = s_r_id[SW-1 -: 2];
      e.vld  = 4'b0001 << ridx;
      e.rdy  = m_r_ready[ridx];
      e.id   = s_r_id[IW-1:0];
      e.data = s_r_data;
      e.resp = s_r_resp;
      e.last = s_r_last;
      e.user = s_r_user;
      exp_r_q.push_back(e);
    end
  endtask

  // Model prediction for the current cycle's inputs, checked mid-cycle.
  task automatic predict_and_check();
    logic [NM-1:0] exp_rdy;
    logic [1:0] j;
    exp_rdy = '0;
    g_ok    = 1'b0;
    g       = 2'd0;
    if (!rst && (!slot_m || s_ar_ready)) begin
      for (int k = 0; k < NM; k++) begin
        j = ptr_m + 2'(k);
        if (!g_ok && pend[j] && cnt_m[j] < MAXO) begin
          g_ok = 1'b1;
          g    = j;
        end
      end
    end
    if (g_ok) exp_rdy[g] = 1'b1;
    check("ar_ready", 128'(m_ar_ready), 128'(exp_rdy));
    check("s_ar_valid", 128'(s_ar_valid), 128'(slot_m));
    r_hs = s_r_valid && m_r_ready[s_r_id[SW-1 -: 2]];
  endtask

  // Advance the model across the clock edge.
  task automatic update_model();
    ar_t e;
    logic [1:0] ridx;
    if (rst) begin
      model_reset();
    end else begin
      if (g_ok) begin
        e.id    = {g, mid[g]};
        e.addr  = maddr[g];
        e.len   = mlen[g];
        e.size  = msize[g];
        e.burst = mbst[g];
        e.snoop = msnp[g];
        e.user  = musr[g];
        exp_ar_q.push_back(e);
        cnt_m[g]++;
        pend[g] = 1'b0;
        ptr_m   = g + 2'd1;
        slot_m  = 1'b1;
      end else if (s_ar_ready) begin
        slot_m = 1'b0;
      end
      if (s_r_valid) begin
        if (r_hs) begin
          ridx = slv_q[cur_k].sid[SW-1 -: 2];
          if (slv_q[cur_k].sent == slv_q[cur_k].len) begin
            cnt_m[ridx]--;
            slv_q.delete(cur_k);
          end else begin
            slv_q[cur_k].sent++;
          end
          r_busy = 1'b0;
        end else begin
          r_busy = 1'b1;
        end
      end
    end
  endtask

  // ---------------- monitors ----------------
  // AR monitor: every downstream AR handshake must match the oldest expected request.
  always @(negedge clk) begin
    ar_t a, e;
    burst_t b;
    if (!rst && s_ar_valid && s_ar_ready) begin
      a = {s_ar_id, s_ar_addr, s_ar_len, s_ar_size, s_ar_burst, s_ar_snoop, s_ar_user};
      if (exp_ar_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL ar_unexpected: got %h expected none", a);
      end else begin
        e = exp_ar_q.pop_front();
        check("s_ar_xfer", 128'(a), 128'(e));
        b.sid  = e.id;
        b.len  = int'(e.len);
        b.sent = 0;
        slv_q.push_back(b);
      end
    end
  end

  // R monitor: every beat offered downstream must appear on the right master.
  always @(negedge clk) begin
    r_t a, e;
    if (s_r_valid) begin
      a = {m_r_valid, s_r_ready, m_r_id, m_r_data, m_r_resp, m_r_last, m_r_user};
      if (exp_r_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL r_unexpected: got %h expected none", a);
      end else begin
        e = exp_r_q.pop_front();
        check("r_route", 128'(a), 128'(e));
      end
    end else if (!rst) begin
      check("r_idle_valid", 128'(m_r_valid), 128'(0));
    end
  end

  // ---------------- main sequence ----------------
  initial begin
    rst        = 1'b1;
    m_ar_valid = '0;
    m_ar_id    = '0;
    m_ar_addr  = '0;
    m_ar_len   = '0;
    m_ar_size  = '0;
    m_ar_burst = '0;
    m_ar_snoop = '0;
    m_ar_user  = '0;
    m_r_ready  = '0;
    s_ar_ready = 1'b0;
    s_r_valid  = 1'b0;
    s_r_id     = '0;
    s_r_data   = '0;
    s_r_resp   = '0;
    s_r_last   = 1'b0;
    s_r_user   = '0;
    cur_k      = 0;
    for (int i = 0; i < NM; i++) pend[i] = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;

    for (int cyc = 0; cyc < 1750; cyc++) begin
      if (cyc < 400) begin
        req_pct = 70; ardy_pct = 100; rrdy_pct = 90; rv_pct = 80;
      end else if (cyc < 800) begin
        req_pct = 50; ardy_pct = 40; rrdy_pct = 60; rv_pct = 70;
      end else if (cyc < 1190) begin
        req_pct = 90; ardy_pct = 90; rrdy_pct = 70; rv_pct = 15;
      end else if (cyc < 1201) begin
        req_pct = 100; ardy_pct = 0; rrdy_pct = 50; rv_pct = 50;
      end else if (cyc < 1600) begin
        req_pct = 60; ardy_pct = 70; rrdy_pct = 50; rv_pct = 60;
      end else begin
        req_pct = 0; ardy_pct = 100; rrdy_pct = 100; rv_pct = 100;
      end
      drive_inputs(cyc);
      @(negedge clk);
      predict_and_check();
      @(posedge clk);
      update_model();
      #1;
    end

    // everything issued must have drained out of the DUT
    @(negedge clk);
    check("ar_drained", 128'(exp_ar_q.size()), 128'(0));
    check("r_drained", 128'(exp_r_q.size()), 128'(0));
    check("bursts_drained", 128'(slv_q.size()), 128'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cache_bus_rd_mux.md
Name: cache_bus_rd_mux

Overview:
- Parametrised N-to-1 multiplexer for the read half of the CacheBus (AR/R channels, including ar_snoop and the 5-bit r_resp).
- Sits between MASTER_NUM cache-side read masters (ICache, DCache, PTW, prefetcher) and one downstream CacheBus slave.
- AR is arbitrated round-robin through a registered output stage; the master index is prepended to the ID; R beats are routed back by the ID MSBs.
- Each master's outstanding read bursts are tracked, and a master is throttled at MAX_OUTSTANDING.

Parameters:
MASTER_NUM, 4, number of upstream read masters (>=2)
ADDR_WIDTH, 32, address width
DATA_WIDTH, 64, R data width
ID_WIDTH, 4, upstream ID width; downstream ID width SID_W = ID_WIDTH + IDX_W, IDX_W = $clog2(MASTER_NUM)
USER_WIDTH, 1, user field width
MAX_OUTSTANDING, 8, max in-flight bursts per master (>=1)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
m_ar_valid  in  MASTER_NUM  per-master AR valid
m_ar_ready  out  MASTER_NUM  per-master AR ready
m_ar_id  in  MASTER_NUM*ID_WIDTH  packed AR ids, master i at [i*ID_WIDTH +: ID_WIDTH]
m_ar_addr  in  MASTER_NUM*ADDR_WIDTH  packed addresses
m_ar_len  in  MASTER_NUM*8  burst lengths
m_ar_size  in  MASTER_NUM*3  beat sizes
m_ar_burst  in  MASTER_NUM*2  burst types
m_ar_snoop  in  MASTER_NUM*4  snoop codes
m_ar_user  in  MASTER_NUM*USER_WIDTH  user fields
m_r_valid  out  MASTER_NUM  per-master R valid
m_r_ready  in  MASTER_NUM  per-master R ready
m_r_id  out  ID_WIDTH  stripped R id, shared by all masters
m_r_data  out  DATA_WIDTH  R data, shared
m_r_resp  out  5  R resp, shared
m_r_last  out  1  R last, shared
m_r_user  out  USER_WIDTH  R user, shared
s_ar_valid  out  1  downstream AR valid
s_ar_ready  in  1  downstream AR ready
s_ar_id  out  SID_W  {master index, master id}
s_ar_addr/len/size/burst/snoop/user  out  as upstream single-master widths  registered AR payload
s_r_valid  in  1  downstream R valid
s_r_ready  out  1  downstream R ready
s_r_id  in  SID_W  downstream R id
s_r_data/resp/last/user  in  DATA_WIDTH/5/1/USER_WIDTH  downstream R payload

Behaviour:
- Reset, synchronous on rst=1 at posedge clk:
  - s_ar_valid=0, output payload regs=0, round-robin pointer=0, all outstanding counters=0.
  - m_ar_ready=0 while rst is high.
- Eligibility: master i is eligible when m_ar_valid[i]=1 and cnt[i] < MAX_OUTSTANDING.
- AR output stage: a single register slot.
  - The slot accepts a new request when it is empty or when s_ar_valid&&s_ar_ready (same-cycle refill allowed, full throughput 1 AR/cycle).
- Arbitration (combinational):
  - When the slot can accept, grant the first eligible master at or after ptr, searching upward modulo MASTER_NUM.
  - m_ar_ready[g]=1 only for the granted master; all others get 0.
  - On handshake, load the slot with {g, m_ar_id[g]} and the payload, and set ptr = (g+1) mod MASTER_NUM.
  - ptr does not change when nothing is granted.
- AR latency: request visible on s_ar_* the cycle after the upstream handshake.
- AR stability: s_ar_valid and payload stay stable until s_ar_ready; the slot never drops or changes a pending request.
- R routing, combinational, zero latency:
  - idx = s_r_id[SID_W-1 -: IDX_W]; m_r_valid[idx] = s_r_valid; the other valid bits are 0.
  - s_r_ready = m_r_ready[idx]; m_r_id = s_r_id[ID_WIDTH-1:0]; data, resp, last and user pass through.
  - Non-power-of-two MASTER_NUM with idx >= MASTER_NUM: s_r_ready=1 (beat dropped), no m_r_valid, and a simulation assertion fires.
- Counters, width $clog2(MAX_OUTSTANDING+1):
  - cnt[i] increments on master i's upstream AR handshake.
  - cnt[i] decrements on an R handshake with r_last=1 and idx=i.
  - Increment and decrement in the same cycle leave cnt unchanged.
  - Decrement at 0 is illegal: assert, and hold at 0.
  - Increment at MAX is impossible by eligibility.
  - The count includes the request sitting in the AR slot.
- Reset mid-burst: all state cleared. The downstream slave is reset in the same domain and must not return stale beats.
- No ordering is guaranteed across masters. Per-master ordering follows the slave's per-ID rules.

Test Plan:
- Single master 0, id=3, addr=0x1000, len=3 → s_ar_id=0x03 one cycle after handshake; four R beats with s_r_id=0x03 → m_r_valid=4'b0001, m_r_id=3; cnt[0] goes 1→0 on the last beat.
- All 4 masters valid continuously, s_ar_ready=1 → grants in order 0,1,2,3,0; one AR per cycle; s_ar_id MSBs = 0,1,2,3,0.
- s_ar_ready=0 for 5 cycles with master 2 pending → s_ar_valid stays 1 with constant payload; no new grant; m_ar_ready all 0 after the slot fills.
- MAX_OUTSTANDING=2, master 1 issues 3 ARs with no R returned → third AR is stalled and masters 0/2/3 are still served; after an r_last for master 1, the third AR is granted the next eligible cycle.
- Interleaved R for masters 1 and 3, m_r_ready[3]=0 → beat for master 3 holds with s_r_ready=0; master 1 beats pass when routed.
- Assert rst for 1 cycle with s_ar_valid=1 and cnt values nonzero → next cycle s_ar_valid=0, all cnt=0, ptr=0.
